// File: rtl/inst_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_sequencer_if                                          |
// | Description : Control/status bundle between a host and inst_sequencer:   |
// |               descriptor writes, start/abort, issued instruction, status.|
// |               INST_SEQ_STALL_EN adds the stall input.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface inst_sequencer_if #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int CNT_BITS    = 16,
  parameter int NUM_DESC    = 16
);
  localparam int IDX_BITS  = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
  localparam int INST_BITS = OPCODE_BITS + 2 * ADDR_BITS;
  localparam int DESC_BITS = OPCODE_BITS + 4 * ADDR_BITS + 2 * CNT_BITS;

  logic                 desc_wen;
  logic [IDX_BITS-1:0]  desc_waddr;
  logic [DESC_BITS-1:0] desc_wdata;
  logic                 start;
  logic                 abort;
`ifdef INST_SEQ_STALL_EN
  logic                 stall;
`endif
  logic [INST_BITS-1:0] instruction;
  logic                 inst_valid;
  logic                 busy;
  logic                 done;
  logic [IDX_BITS-1:0]  cur_desc;

  // Host side: programs the table and controls the run
  modport master (
    output desc_wen, desc_waddr, desc_wdata, start, abort,
`ifdef INST_SEQ_STALL_EN
    output stall,
`endif
    input  instruction, inst_valid, busy, done, cur_desc
  );

  // Sequencer side
  modport slave (
    input  desc_wen, desc_waddr, desc_wdata, start, abort,
`ifdef INST_SEQ_STALL_EN
    input  stall,
`endif
    output instruction, inst_valid, busy, done, cur_desc
  );
endinterface
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_sequencer                                             |
// | Description : Runs a table of loop descriptors, issuing one opcode ITERS |
// |               times with strided ADDRA/ADDRB and a per-instruction hold. |
// |               Descriptor: {OPCODE,A_BASE,A_STRIDE,B_BASE,B_STRIDE,       |
// |               ITERS,HOLD}; ITERS==0 marks the end of the program.        |
// |               Optional: INST_SEQ_STALL_EN adds a stall input that        |
// |               freezes issue.                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module inst_sequencer #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int CNT_BITS    = 16,
  parameter int NUM_DESC    = 16,
  parameter int IDLE_OPCODE = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  inst_sequencer_if.slave   bus
);
  localparam int IDX_BITS  = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
  localparam int INST_BITS = OPCODE_BITS + 2 * ADDR_BITS;
  localparam int DESC_BITS = OPCODE_BITS + 4 * ADDR_BITS + 2 * CNT_BITS;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_issue = 2'd2;

  localparam logic [INST_BITS-1:0] c_idle_inst =
    {OPCODE_BITS'(IDLE_OPCODE), {(2 * ADDR_BITS){1'b0}}};
  localparam logic [IDX_BITS-1:0] c_last_desc = IDX_BITS'(NUM_DESC - 1);

  logic [DESC_BITS-1:0] r_table [NUM_DESC];
  logic [1:0]           r_state;
  logic [IDX_BITS-1:0]  r_cur_desc;
  logic [ADDR_BITS-1:0] r_addra;
  logic [ADDR_BITS-1:0] r_addrb;
  logic [CNT_BITS-1:0]  r_iter;
  logic [CNT_BITS-1:0]  r_hold_cnt;
  logic [INST_BITS-1:0] r_instruction;
  logic                 r_valid;
  logic                 r_done;

  logic                   w_busy;
  logic                   w_stall;
  logic [DESC_BITS-1:0]   w_desc;
  logic [OPCODE_BITS-1:0] w_opcode;
  logic [ADDR_BITS-1:0]   w_a_base;
  logic [ADDR_BITS-1:0]   w_a_stride;
  logic [ADDR_BITS-1:0]   w_b_base;
  logic [ADDR_BITS-1:0]   w_b_stride;
  logic [CNT_BITS-1:0]    w_iters;
  logic [CNT_BITS-1:0]    w_hold;
  logic [CNT_BITS-1:0]    w_hold_eff;
  logic                   w_expire;
  logic                   w_last_iter;
  logic [ADDR_BITS-1:0]   w_addra_nxt;
  logic [ADDR_BITS-1:0]   w_addrb_nxt;

  // The table is only writable while idle, so the descriptor selected by
  // r_cur_desc stays stable for the whole LOAD/ISSUE span and is read directly.
  assign w_desc      = r_table[r_cur_desc];
  assign w_opcode    = w_desc[DESC_BITS-1 -: OPCODE_BITS];
  assign w_a_base    = w_desc[4*ADDR_BITS+2*CNT_BITS-1 -: ADDR_BITS];
  assign w_a_stride  = w_desc[3*ADDR_BITS+2*CNT_BITS-1 -: ADDR_BITS];
  assign w_b_base    = w_desc[2*ADDR_BITS+2*CNT_BITS-1 -: ADDR_BITS];
  assign w_b_stride  = w_desc[ADDR_BITS+2*CNT_BITS-1 -: ADDR_BITS];
  assign w_iters     = w_desc[2*CNT_BITS-1 -: CNT_BITS];
  assign w_hold      = w_desc[CNT_BITS-1:0];

  // HOLD==0 behaves as a single-cycle hold; the counter runs 1..w_hold_eff.
  assign w_hold_eff  = (w_hold == '0) ? CNT_BITS'(1) : w_hold;
  assign w_expire    = (r_hold_cnt == w_hold_eff);
  assign w_last_iter = (r_iter == (w_iters - CNT_BITS'(1)));
  assign w_addra_nxt = r_addra + w_a_stride;
  assign w_addrb_nxt = r_addrb + w_b_stride;
  assign w_busy      = (r_state != c_st_idle);

`ifdef INST_SEQ_STALL_EN
  assign w_stall        = bus.stall;
  // A pending pulse is withheld while stalled and released on the first free cycle.
  assign bus.inst_valid = r_valid & ~bus.stall;
`else
  assign w_stall        = 1'b0;
  assign bus.inst_valid = r_valid;
`endif

  assign bus.instruction = r_instruction;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.cur_desc    = r_cur_desc;

  // Descriptor table write port; writes while a program runs are dropped
  always_ff @(posedge clk) begin
    if (bus.desc_wen && !w_busy) begin
      r_table[bus.desc_waddr] <= bus.desc_wdata;
    end
  end

  // Sequencer FSM: IDLE -> LOAD -> ISSUE -> (ISSUE | LOAD | IDLE)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_st_idle;
      r_cur_desc    <= '0;
      r_addra       <= '0;
      r_addrb       <= '0;
      r_iter        <= '0;
      r_hold_cnt    <= '0;
      r_instruction <= c_idle_inst;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (bus.abort) begin
        r_state       <= c_st_idle;
        r_instruction <= c_idle_inst;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (bus.start) begin
              r_state    <= c_st_load;
              r_cur_desc <= '0;
            end
          end
          c_st_load: begin
            if (w_iters == '0) begin
              r_state <= c_st_idle;
              r_done  <= 1'b1;
            end else begin
              r_addra       <= w_a_base;
              r_addrb       <= w_b_base;
              r_iter        <= '0;
              r_hold_cnt    <= CNT_BITS'(1);
              r_instruction <= {w_opcode, w_a_base, w_b_base};
              r_valid       <= 1'b1;
              r_state       <= c_st_issue;
            end
          end
          c_st_issue: begin
            if (w_stall) begin
              r_valid <= r_valid;
            end else if (!w_expire) begin
              r_hold_cnt <= r_hold_cnt + CNT_BITS'(1);
            end else if (!w_last_iter) begin
              r_addra       <= w_addra_nxt;
              r_addrb       <= w_addrb_nxt;
              r_iter        <= r_iter + CNT_BITS'(1);
              r_hold_cnt    <= CNT_BITS'(1);
              r_instruction <= {w_opcode, w_addra_nxt, w_addrb_nxt};
              r_valid       <= 1'b1;
            end else begin
              r_instruction <= c_idle_inst;
              if (r_cur_desc == c_last_desc) begin
                // Full table consumed: finish rather than wrap to descriptor 0
                r_state <= c_st_idle;
                r_done  <= 1'b1;
              end else begin
                r_cur_desc <= r_cur_desc + IDX_BITS'(1);
                r_state    <= c_st_load;
              end
            end
          end
          default: begin
            r_state       <= c_st_idle;
            r_instruction <= c_idle_inst;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire
